// File: rtl/frog_sprite_line_if.sv
// Sprite ROM read port: the renderer drives enable/address and the ROM
// returns the 4-bit palette index one cycle later.
interface frog_sprite_line_if #(
    parameter int unsigned ROM_AW = 8
);
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/frog_sprite_line.sv
// Single-sprite line renderer: fetches the next scanline's sprite row into a line
// buffer during hblank, then emits palette colours retimed one cycle with sync/de.
module frog_sprite_line #(
    parameter int unsigned CORDW   = 16,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned SPR_W   = 16,
    parameter int unsigned SPR_H   = 16,
    parameter int unsigned ROM_AW  = 8
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de,
    input  logic                    line,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic signed [CORDW-1:0] spr_x,
    input  logic signed [CORDW-1:0] spr_y,
    frog_sprite_line_if.master      rom,
    input  logic                    pal_we,
    input  logic [3:0]              pal_addr,
    input  logic [11:0]             pal_data,
    output logic [11:0]             pix_color,
    output logic                    pix_opaque,
    output logic                    de_o,
    output logic                    hsync_o,
    output logic                    vsync_o
);

    localparam int unsigned XW     = CORDW + 1;
    localparam int unsigned BUF_AW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned COLW   = $clog2(SPR_W + 1);
    localparam int unsigned ROWW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COLW-1:0]     col_q, col_d;
    logic [ROWW-1:0]     row_q, row_d;
    logic                row_valid_q, row_valid_d;
    logic                rom_en_q, rom_en_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                buf_we;
    logic [BUF_AW-1:0]   buf_idx;

    logic signed [CORDW-1:0] spr_x_l, spr_y_l;
    logic signed [CORDW-1:0] next_sy;
    logic signed [XW-1:0]    row_full;
    logic signed [XW-1:0]    dx;
    logic                    row_in, dx_in, hit;
    logic [3:0]              pix_idx;

    logic [3:0]  lbuf [SPR_W];
    logic [11:0] pal  [16];

    assign rom.rom_en   = rom_en_q;
    assign rom.rom_addr = rom_addr_q;

    // Sprite row wanted on the line after this one, with frame wrap.
    assign next_sy  = (sy == CORDW'(V_TOTAL - 1)) ? '0 : sy + CORDW'(1);
    assign row_full = {next_sy[CORDW-1], next_sy} - {spr_y_l[CORDW-1], spr_y_l};
    assign row_in   = !row_full[XW-1] && (row_full < XW'(SPR_H));

    assign dx      = {sx[CORDW-1], sx} - {spr_x_l[CORDW-1], spr_x_l};
    assign dx_in   = !dx[XW-1] && (dx < XW'(SPR_W));
    assign pix_idx = dx_in ? lbuf[BUF_AW'(dx)] : 4'd0;
    assign hit     = de && row_valid_q && dx_in && (pix_idx != 4'd0);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_valid_q <= row_valid_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    // col counts the next column to issue; data arriving now belongs to col-2.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        row_valid_d = row_valid_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        buf_we      = 1'b0;
        buf_idx     = '0;
        unique case (state_q)
            IDLE: begin
                if (sx == CORDW'(H_RES)) begin
                    row_valid_d = 1'b0;
                    if (row_in) begin
                        row_d      = ROWW'(row_full);
                        col_d      = COLW'(1);
                        rom_en_d   = 1'b1;
                        rom_addr_d = ROM_AW'(row_d) * ROM_AW'(SPR_W);
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                if (col_q >= COLW'(2)) begin
                    buf_we  = 1'b1;
                    buf_idx = BUF_AW'(col_q - COLW'(2));
                end
                if (col_q < COLW'(SPR_W)) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = ROM_AW'(row_q) * ROM_AW'(SPR_W) + ROM_AW'(col_q);
                    col_d      = col_q + COLW'(1);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                buf_we      = 1'b1;
                buf_idx     = BUF_AW'(SPR_W - 1);
                row_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (buf_we) lbuf[buf_idx] <= rom.rom_data;
    end

    // Position is sampled once per frame at the start of vblank.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            spr_x_l <= '0;
            spr_y_l <= '0;
        end else if (line && (sy == CORDW'(V_RES))) begin
            spr_x_l <= spr_x;
            spr_y_l <= spr_y;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < 16; i++) pal[i] <= '0;
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            pix_opaque <= 1'b0;
            pix_color  <= '0;
            de_o       <= 1'b0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
        end else begin
            pix_opaque <= hit;
            pix_color  <= hit ? pal[pix_idx] : 12'h000;
            de_o       <= de;
            hsync_o    <= hsync;
            vsync_o    <= vsync;
        end
    end

endmodule
